// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage <-> scoreboard hazard unit signal bundle.
// The ID stage drives the decoded instruction; the hazard unit returns stall/issue status.
interface scoreboard_hazard_unit_if #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int LW   = 3,
   parameter int CW   = 16
);
   logic            id_valid;
   logic [AW-1:0]   id_rs;
   logic [AW-1:0]   id_rt;
   logic            id_rs_used;
   logic            id_rt_used;
   logic [AW-1:0]   id_rd;
   logic            id_regwrite;
   logic [LW-1:0]   id_lat;
   logic            id_long;
   logic            flush;
   logic            stall;
   logic            issue;
   logic            long_busy;
   logic [NREG-1:0] pending;
   logic [CW-1:0]   stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_regwrite,
             id_lat, id_long, flush,
      input  stall, issue, long_busy, pending, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_regwrite,
             id_lat, id_long, flush,
      output stall, issue, long_busy, pending, stall_cnt
   );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Per-register latency scoreboard deciding when the ID stage may advance.
// Covers RAW, WAW-ordering and long-unit structural hazards with a single stall output.
module scoreboard_hazard_unit #(
   parameter int NREG     = 32,
   parameter int AW       = 5,
   parameter int LW       = 3,
   parameter int LONG_LAT = 6,
   parameter int CW       = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   scoreboard_hazard_unit_if.slave sb
);

   localparam logic [LW-1:0] LONG_LAT_V = LW'(LONG_LAT);

   // Register 0 is hard-wired zero, so its counter simply does not exist.
   logic [LW-1:0]   cnt_q [1:NREG-1];
   logic [LW-1:0]   cnt_d [1:NREG-1];
   logic [LW-1:0]   busy_q, busy_d;
   logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
   logic [LW-1:0]   rs_cnt, rt_cnt, rd_cnt;
   logic [NREG-1:0] pending;
   logic            raw, waw, str, live, stall, issue;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      rs_cnt = '0;
      rt_cnt = '0;
      rd_cnt = '0;
      for (int r = 1; r < NREG; r++) begin
         if (sb.id_rs == AW'(r)) rs_cnt = cnt_q[r];
         if (sb.id_rt == AW'(r)) rt_cnt = cnt_q[r];
         if (sb.id_rd == AW'(r)) rd_cnt = cnt_q[r];
      end
   end

   // Index 0 never matches above, so its lookups read as zero.
   assign raw   = (sb.id_rs_used && rs_cnt != '0) || (sb.id_rt_used && rt_cnt != '0);
   assign waw   = sb.id_regwrite && sb.id_rd != '0 && sb.id_lat < rd_cnt;
   assign str   = sb.id_long && busy_q != '0;
   assign live  = sb.id_valid && !sb.flush;
   assign stall = live && (raw || waw || str);
   assign issue = live && !stall;

   always_comb begin
      for (int r = 1; r < NREG; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : cnt_q[r];
         if (issue && sb.id_regwrite && sb.id_rd == AW'(r) && sb.id_lat != '0)
            cnt_d[r] = sb.id_lat;
      end

      if (issue && sb.id_long)  busy_d = LONG_LAT_V;
      else if (busy_q != '0)    busy_d = busy_q - 1'b1;
      else                      busy_d = busy_q;

      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != {CW{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // NOTE: the counter array is reset too, because stale latencies after reset would cause false stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
         busy_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         busy_q      <= busy_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      pending = '0;
      for (int r = 1; r < NREG; r++) pending[r] = (cnt_q[r] != '0);
   end

   assign sb.stall     = stall;
   assign sb.issue     = issue;
   assign sb.long_busy = (busy_q != '0);
   assign sb.pending   = pending;
   assign sb.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: hand-computed vector table, reset sequence,
// then random stimulus compared with a cycle-count reference model.
module tb_scoreboard_hazard_unit;

   localparam int NREG     = 32;
   localparam int AW       = 5;
   localparam int LW       = 3;
   localparam int LONG_LAT = 6;
   localparam int CW       = 16;

   typedef struct {
      bit        valid;
      bit [4:0]  rs;
      bit        rs_used;
      bit [4:0]  rt;
      bit        rt_used;
      bit [4:0]  rd;
      bit        regwrite;
      bit [2:0]  lat;
      bit        long_op;
      bit        flush;
      bit        rst_n;
      bit        e_stall;
      bit        e_issue;
      bit        e_lb;
      bit [31:0] e_pend;
      int        e_sc;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference state: cycles until each register's result is forwardable.
   int   m_cnt [NREG];
   int   m_busy;
   int   m_sc;

   vec_t tbl [$];

   scoreboard_hazard_unit_if #(.NREG(NREG), .AW(AW), .LW(LW), .CW(CW)) sb_if ();

   scoreboard_hazard_unit #(
      .NREG(NREG), .AW(AW), .LW(LW), .LONG_LAT(LONG_LAT), .CW(CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit valid, bit [4:0] rs, bit ru, bit [4:0] rt, bit tu,
                               bit [4:0] rd, bit rw, bit [2:0] lat, bit lg, bit fl, bit rn,
                               bit st, bit is, bit lb, bit [31:0] pend, int sc);
      vec_t v;
      v.valid = valid; v.rs = rs; v.rs_used = ru; v.rt = rt; v.rt_used = tu;
      v.rd = rd; v.regwrite = rw; v.lat = lat; v.long_op = lg; v.flush = fl; v.rst_n = rn;
      v.e_stall = st; v.e_issue = is; v.e_lb = lb; v.e_pend = pend; v.e_sc = sc;
      return v;
   endfunction

   function automatic void m_eval(input vec_t v, output bit st, output bit is);
      bit raw, waw, str, live;
      raw  = (v.rs_used && v.rs != 0 && m_cnt[v.rs] > 0) ||
             (v.rt_used && v.rt != 0 && m_cnt[v.rt] > 0);
      waw  = v.regwrite && v.rd != 0 && int'(v.lat) < m_cnt[v.rd];
      str  = v.long_op && m_busy > 0;
      live = v.valid && !v.flush;
      st   = live && (raw || waw || str);
      is   = live && !st;
   endfunction

   function automatic bit [31:0] m_pending();
      bit [31:0] p = '0;
      for (int r = 1; r < NREG; r++) p[r] = (m_cnt[r] > 0);
      return p;
   endfunction

   // mode 0: no checks, 1: compare with the vector's own expectations, 2: compare with the model.
   task automatic step(input vec_t v, input int mode, input string tag);
      bit st, is;
      sb_if.id_valid    = v.valid;
      sb_if.id_rs       = v.rs;
      sb_if.id_rt       = v.rt;
      sb_if.id_rs_used  = v.rs_used;
      sb_if.id_rt_used  = v.rt_used;
      sb_if.id_rd       = v.rd;
      sb_if.id_regwrite = v.regwrite;
      sb_if.id_lat      = v.lat;
      sb_if.id_long     = v.long_op;
      sb_if.flush       = v.flush;
      rst_n             = v.rst_n;
      #2;
      m_eval(v, st, is);
      if (mode == 1) begin
         check({tag, " stall"},     sb_if.stall,     v.e_stall);
         check({tag, " issue"},     sb_if.issue,     v.e_issue);
         check({tag, " long_busy"}, sb_if.long_busy, v.e_lb);
         check({tag, " pending"},   sb_if.pending,   v.e_pend);
         check({tag, " stall_cnt"}, sb_if.stall_cnt, 64'(v.e_sc));
      end else if (mode == 2) begin
         check({tag, " stall"},     sb_if.stall,     st);
         check({tag, " issue"},     sb_if.issue,     is);
         check({tag, " long_busy"}, sb_if.long_busy, m_busy > 0);
         check({tag, " pending"},   sb_if.pending,   m_pending());
         check({tag, " stall_cnt"}, sb_if.stall_cnt, 64'(m_sc));
      end
      @(posedge clk);
      #1;
      if (!v.rst_n) begin
         foreach (m_cnt[r]) m_cnt[r] = 0;
         m_busy = 0;
         m_sc   = 0;
      end else begin
         foreach (m_cnt[r]) if (m_cnt[r] > 0) m_cnt[r]--;
         if (is && v.regwrite && v.rd != 0 && v.lat != 0) m_cnt[v.rd] = v.lat;
         if (is && v.long_op) m_busy = LONG_LAT;
         else if (m_busy > 0) m_busy--;
         if (st && m_sc < (1 << CW) - 1) m_sc++;
      end
   endtask

   initial begin
      vec_t idle, v;
      idle = mk(0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0);
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_busy = 0;
      m_sc   = 0;

      // Load-use
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,0,32'h0,  0));
      tbl.push_back(mk(1,1,1,0,0, 2,1,1,0,0,1, 0,1,0,32'h0,  0));
      tbl.push_back(mk(1,2,1,4,1, 3,1,0,0,0,1, 1,0,0,32'h4,  0));
      tbl.push_back(mk(1,2,1,4,1, 3,1,0,0,0,1, 0,1,0,32'h0,  1));
      // Mul chain through the long unit
      tbl.push_back(mk(1,1,1,1,1, 5,1,3,1,0,1, 0,1,0,32'h0,  1));
      tbl.push_back(mk(1,5,1,0,0, 7,1,0,0,0,1, 1,0,1,32'h20, 1));
      tbl.push_back(mk(1,5,1,0,0, 7,1,0,0,0,1, 1,0,1,32'h20, 2));
      tbl.push_back(mk(1,5,1,0,0, 7,1,0,0,0,1, 1,0,1,32'h20, 3));
      tbl.push_back(mk(1,5,1,0,0, 7,1,0,0,0,1, 0,1,1,32'h0,  4));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,1,32'h0,  4));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,1,32'h0,  4));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,0,32'h0,  4));
      // WAW: short write behind a longer one
      tbl.push_back(mk(1,0,0,0,0, 6,1,4,0,0,1, 0,1,0,32'h0,  4));
      tbl.push_back(mk(1,0,0,0,0, 6,1,0,0,0,1, 1,0,0,32'h40, 4));
      tbl.push_back(mk(1,0,0,0,0, 6,1,0,0,0,1, 1,0,0,32'h40, 5));
      tbl.push_back(mk(1,0,0,0,0, 6,1,0,0,0,1, 1,0,0,32'h40, 6));
      tbl.push_back(mk(1,0,0,0,0, 6,1,0,0,0,1, 1,0,0,32'h40, 7));
      tbl.push_back(mk(1,0,0,0,0, 6,1,0,0,0,1, 0,1,0,32'h0,  8));
      // WAW boundary: equal latency issues and reloads the counter
      tbl.push_back(mk(1,0,0,0,0, 6,1,4,0,0,1, 0,1,0,32'h0,  8));
      tbl.push_back(mk(1,0,0,0,0, 6,1,3,0,0,1, 1,0,0,32'h40, 8));
      tbl.push_back(mk(1,0,0,0,0, 6,1,3,0,0,1, 0,1,0,32'h40, 9));
      tbl.push_back(mk(1,6,1,0,0, 7,1,0,0,0,1, 1,0,0,32'h40, 9));
      tbl.push_back(mk(1,6,1,0,0, 7,1,0,0,0,1, 1,0,0,32'h40, 10));
      tbl.push_back(mk(1,6,1,0,0, 7,1,0,0,0,1, 1,0,0,32'h40, 11));
      tbl.push_back(mk(1,6,1,0,0, 7,1,0,0,0,1, 0,1,0,32'h0,  12));
      // Structural: back-to-back divides
      tbl.push_back(mk(1,0,0,0,0, 8,1,2,1,0,1, 0,1,0,32'h0,  12));
      tbl.push_back(mk(1,0,0,0,0, 9,1,2,1,0,1, 1,0,1,32'h100,12));
      tbl.push_back(mk(1,0,0,0,0, 9,1,2,1,0,1, 1,0,1,32'h100,13));
      tbl.push_back(mk(1,0,0,0,0, 9,1,2,1,0,1, 1,0,1,32'h0,  14));
      tbl.push_back(mk(1,0,0,0,0, 9,1,2,1,0,1, 1,0,1,32'h0,  15));
      tbl.push_back(mk(1,0,0,0,0, 9,1,2,1,0,1, 1,0,1,32'h0,  16));
      tbl.push_back(mk(1,0,0,0,0, 9,1,2,1,0,1, 1,0,1,32'h0,  17));
      tbl.push_back(mk(1,0,0,0,0, 9,1,2,1,0,1, 0,1,0,32'h0,  18));
      // Flush beats stall and records nothing; r0 is never tracked
      tbl.push_back(mk(1,9,1,0,0,10,1,3,0,1,1, 0,0,1,32'h200,18));
      tbl.push_back(mk(1,9,1,0,0,10,1,3,0,0,1, 1,0,1,32'h200,18));
      tbl.push_back(mk(1,0,0,0,0, 0,1,5,0,0,1, 0,1,1,32'h0,  19));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,1,32'h0,  19));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,1,32'h0,  19));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,1,32'h0,  19));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,0,32'h0,  19));
      tbl.push_back(mk(1,0,0,0,0,11,1,2,1,1,1, 0,0,0,32'h0,  19));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,0,32'h0,  19));

      v = idle;
      v.rst_n = 1'b0;
      step(v, 0, "init");
      step(v, 0, "init");

      foreach (tbl[i]) step(tbl[i], 1, $sformatf("vec%0d", i));

      // Reset while cnt[5]=3 and the long unit has 4 cycles left
      step(mk(1,0,0,0,0,11,1,0,1,0,1, 0,1,0,32'h0,  19), 1, "rst_a");
      step(mk(0,0,0,0,0, 0,0,0,0,0,1, 0,0,1,32'h0,  19), 1, "rst_b");
      step(mk(1,0,0,0,0, 5,1,3,0,0,1, 0,1,1,32'h0,  19), 1, "rst_c");
      step(mk(1,5,1,0,0,12,1,0,0,0,0, 1,0,1,32'h20, 19), 1, "rst_d");
      step(mk(1,5,1,0,0,12,1,0,0,0,1, 0,1,0,32'h0,  0),  1, "rst_e");
      // Issue during reset records nothing
      step(mk(1,0,0,0,0, 5,1,3,1,0,0, 0,1,0,32'h0,  0),  1, "rst_f");
      step(mk(1,5,1,0,0,12,1,0,1,0,1, 0,1,0,32'h0,  0),  1, "rst_g");

      for (int i = 0; i < 600; i++) begin
         v.valid    = ($urandom_range(0, 9) != 0);
         v.rs       = 5'($urandom_range(0, 7));
         v.rt       = 5'($urandom_range(0, 7));
         v.rs_used  = 1'($urandom_range(0, 1));
         v.rt_used  = 1'($urandom_range(0, 1));
         v.rd       = 5'($urandom_range(0, 7));
         v.regwrite = 1'($urandom_range(0, 1));
         v.lat      = 3'($urandom_range(0, 7));
         v.long_op  = ($urandom_range(0, 5) == 0);
         v.flush    = ($urandom_range(0, 11) == 0);
         v.rst_n    = ($urandom_range(0, 79) != 0);
         step(v, 2, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
